// File: rtl/mix512_pkg.sv
// rtl/mix512_pkg.sv - shared constants, index tables and word-array type for the Haraka-512 word mix
//
// Purpose: one place for the 512-bit state geometry and the two word-index
// tables, so the permutation sub-module and the stream wrapper agree.
// Ports: none (package).

package mix512_pkg;

  localparam int NUM_CHUNKS     = 16;
  localparam int CHUNK_W        = 32;
  localparam int BEAT_W         = 128;
  localparam int BEATS          = 4;
  localparam int WORDS_PER_BEAT = NUM_CHUNKS / BEATS;

  // Word 0 sits at bits [31:0], matching the beat packing on the stream.
  typedef logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] word_arr_t;

  typedef int idx_table_t [NUM_CHUNKS];

  // Output word k takes source word TABLE[k].
  localparam idx_table_t FWD_IDX = '{3, 11, 7, 15, 8, 0, 12, 4, 9, 1, 13, 5, 2, 10, 6, 14};
  localparam idx_table_t INV_IDX = '{5, 9, 12, 0, 7, 11, 14, 2, 4, 8, 13, 1, 6, 10, 15, 3};

  function automatic int src_idx(input int inverse, input int k);
    return (inverse != 0) ? INV_IDX[k] : FWD_IDX[k];
  endfunction

endpackage

// File: rtl/inv_mix512.sv
// rtl/inv_mix512.sv - combinational Haraka-512 word mix (inverse or forward)
//
// Purpose: pure wiring permutation of sixteen 32-bit words.
// Ports:
//   in_state  - 512-bit source state, word 0 at bits [31:0]
//   out_state - 512-bit mixed state, out word k = in word TABLE[k]
// Parameter INVERSE: 1 selects the inverse table, 0 the forward table.

module inv_mix512
  import mix512_pkg::*;
#(
  parameter int INVERSE = 1
) (
  input  logic [NUM_CHUNKS*CHUNK_W-1:0] in_state,
  output logic [NUM_CHUNKS*CHUNK_W-1:0] out_state
);

  for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_word
    localparam int SRC = src_idx(INVERSE, k);
    assign out_state[k*CHUNK_W +: CHUNK_W] = in_state[SRC*CHUNK_W +: CHUNK_W];
  end

endmodule

// File: rtl/inv_mix512_stream.sv
// rtl/inv_mix512_stream.sv - ping-pong buffered streaming wrapper around the 512-bit word mix
//
// Purpose: collects four 128-bit beats into one 512-bit state, mixes the
// words, and streams the result back out as four beats. Two banks let one
// block fill while the previous one drains, giving one beat per cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake, in_data carries one 128-bit beat
//   out_valid/out_ready - output handshake, out_data carries one 128-bit beat
//   out_last            - marks the fourth beat of each output block
// Parameter INVERSE: 1 inverse mix, 0 forward mix.

module inv_mix512_stream
  import mix512_pkg::*;
#(
  parameter int INVERSE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last
);

  word_arr_t  bank_q [2];
  word_arr_t  bank_d [2];
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] in_cnt_q, in_cnt_d;
  logic [1:0] out_cnt_q, out_cnt_d;

  logic       in_fire, out_fire;
  word_arr_t  rd_bank;
  word_arr_t  mixed;
  logic [NUM_CHUNKS*CHUNK_W-1:0] mixed_flat;

  // Both handshakes depend only on flops, so a freed bank shows up as
  // in_ready one cycle after the draining transfer, never combinationally.
  assign in_ready  = !full_q[wr_ptr_q];
  assign out_valid = full_q[rd_ptr_q];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;

    if (in_fire) begin
      bank_d[wr_ptr_q][{in_cnt_q, 2'b00} +: WORDS_PER_BEAT] = in_data;
      in_cnt_d = in_cnt_q + 2'd1;
      if (in_cnt_q == 2'd3) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = !wr_ptr_q;
      end
    end

    // A filling bank is never full and a draining bank always is, so the set
    // above and the clear below can only ever hit different banks.
    if (out_fire) begin
      out_cnt_d = out_cnt_q + 2'd1;
      if (out_cnt_q == 2'd3) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = !rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      in_cnt_q  <= 2'd0;
      out_cnt_q <= 2'd0;
    end else begin
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
    // Bank contents are meaningless until a block is marked full.
    bank_q[0] <= bank_d[0];
    bank_q[1] <= bank_d[1];
  end

  assign rd_bank = bank_q[rd_ptr_q];

  inv_mix512 #(
    .INVERSE(INVERSE)
  ) u_mix (
    .in_state (rd_bank),
    .out_state(mixed_flat)
  );

  assign mixed    = mixed_flat;
  assign out_data = out_valid ? mixed[{out_cnt_q, 2'b00} +: WORDS_PER_BEAT] : '0;
  assign out_last = out_valid && (out_cnt_q == 2'd3);

endmodule

// File: tb/tb_inv_mix512_stream.sv
// tb/tb_inv_mix512_stream.sv - scoreboard bench for the streaming 512-bit word mix

module tb_inv_mix512_stream;

  typedef logic [15:0][31:0] st_t;

  localparam int FWD_T [16] = '{3, 11, 7, 15, 8, 0, 12, 4, 9, 1, 13, 5, 2, 10, 6, 14};
  localparam int INV_T [16] = '{5, 9, 12, 0, 7, 11, 14, 2, 4, 8, 13, 1, 6, 10, 15, 3};

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic [1:0]   in_rdy;
  logic [1:0]   o_vld;
  logic [1:0]   o_last;
  logic [127:0] o_data [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_mode = 0;

  // index 0: INVERSE=1 instance, index 1: INVERSE=0 instance
  logic [128:0] exp_q [2][$];

  inv_mix512_stream #(.INVERSE(1)) u_inv (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_data(o_data[0]), .out_last(o_last[0])
  );

  inv_mix512_stream #(.INVERSE(0)) u_fwd (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_data(o_data[1]), .out_last(o_last[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic st_t mix(input bit inv, input st_t s);
    st_t r;
    for (int k = 0; k < 16; k++) r[k] = s[inv ? INV_T[k] : FWD_T[k]];
    return r;
  endfunction

  function automatic st_t rand_st();
    st_t r;
    for (int k = 0; k < 16; k++) r[k] = $urandom;
    return r;
  endfunction

  function automatic st_t iota_st();
    st_t r;
    for (int k = 0; k < 16; k++) r[k] = k;
    return r;
  endfunction

  task automatic push_exp(input st_t e0, input st_t e1);
    for (int b = 0; b < 4; b++) begin
      exp_q[0].push_back({b == 3, e0[b*4 +: 4]});
      exp_q[1].push_back({b == 3, e1[b*4 +: 4]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat until accepted; leaves in_valid as-is on return.
  task automatic send_beat(input logic [127:0] d);
    int waited = 0;
    forever begin
      if (rand_mode && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = d;
      end
      if (rand_mode) out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      if (in_valid && in_rdy[0]) begin
        tick();
        return;
      end
      tick();
      waited++;
      if (waited > 300) begin
        check(1'b0, "in_timeout", 129'(waited), 129'(300));
        return;
      end
    end
  endtask

  task automatic send_block(input st_t din, input st_t e0, input st_t e1);
    push_exp(e0, e1);
    for (int b = 0; b < 4; b++) send_beat(din[b*4 +: 4]);
  endtask

  task automatic drain();
    int w = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && w < 1000) begin
      tick();
      w++;
    end
    check(exp_q[0].size() == 0 && exp_q[1].size() == 0, "drain",
          129'(exp_q[0].size() + exp_q[1].size()), 129'(0));
  endtask

  task automatic check_idle_state(input string nm);
    check(in_rdy == 2'b11 && o_vld == 2'b00 && o_last == 2'b00 &&
          o_data[0] == '0 && o_data[1] == '0, nm,
          129'({in_rdy, o_vld, o_last}), 129'(6'b110000));
  endtask

  // Output monitor: pops expectations on every transfer and checks stalls.
  initial begin
    bit           stall [2];
    logic [128:0] prev  [2];
    logic [128:0] exp;
    stall[0] = 0;
    stall[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          stall[d] = 0;
        end else begin
          if (stall[d])
            check(o_vld[d] && ({o_last[d], o_data[d]} == prev[d]), "stall_hold",
                  {o_last[d], o_data[d]}, prev[d]);
          if (o_vld[d] && out_ready) begin
            if (exp_q[d].size() == 0) begin
              check(1'b0, "unexpected_beat", {o_last[d], o_data[d]}, '0);
            end else begin
              exp = exp_q[d].pop_front();
              check({o_last[d], o_data[d]} == exp, d == 0 ? "beat_inv" : "beat_fwd",
                    {o_last[d], o_data[d]}, exp);
            end
          end else if (!o_vld[d]) begin
            check(o_data[d] == '0 && !o_last[d], "idle_zero", {o_last[d], o_data[d]}, '0);
          end
          stall[d] = o_vld[d] && !out_ready;
          prev[d]  = {o_last[d], o_data[d]};
        end
      end
    end
  end

  initial begin
    st_t s, f, blk [3];
    int  acc, n;
    bit  done;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_idle_state("reset_during");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_state("reset_after");
    tick();

    // Known pattern with latency probe on the fourth beat.
    s = iota_st();
    push_exp(mix(1, s), mix(0, s));
    for (int b = 0; b < 3; b++) send_beat(s[b*4 +: 4]);
    in_valid = 1'b1;
    in_data  = s[12 +: 4];
    @(negedge clk);
    check(in_rdy[0] && !o_vld[0], "lat_before", 129'({in_rdy[0], o_vld[0]}), 129'(2'b10));
    tick();
    in_valid = 1'b0;
    check(o_vld[0] == 1'b1, "lat_after", 129'(o_vld[0]), 129'(1));
    drain();

    // Backpressure: both banks fill, nothing more is taken.
    out_ready = 1'b0;
    blk[0] = rand_st();
    blk[1] = rand_st();
    blk[2] = rand_st();
    push_exp(mix(1, blk[0]), mix(0, blk[0]));
    push_exp(mix(1, blk[1]), mix(0, blk[1]));
    acc = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid = 1'b1;
      in_data  = (acc < 12) ? blk[acc/4][(acc%4)*4 +: 4] : '0;
      @(negedge clk);
      if (in_rdy[0]) acc++;
      tick();
    end
    check(acc == 8, "bp_accept_count", 129'(acc), 129'(8));
    check(in_rdy[0] == 1'b0, "bp_in_ready_low", 129'(in_rdy[0]), 129'(0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (o_vld[0]) n++;
      if (n == 4) begin
        check(in_rdy[0] == 1'b0, "free_not_comb", 129'(in_rdy[0]), 129'(0));
        tick();
        check(in_rdy[0] == 1'b1, "free_next_cycle", 129'(in_rdy[0]), 129'(1));
        done = 1;
      end else begin
        tick();
      end
    end
    check(done, "bp_drain_timeout", 129'(n), 129'(4));
    drain();

    // Three blocks back to back at full rate.
    for (int i = 0; i < 3; i++) begin
      blk[i] = rand_st();
      push_exp(mix(1, blk[i]), mix(0, blk[i]));
    end
    for (int t = 0; t < 17; t++) begin
      if (t < 12) begin
        in_valid = 1'b1;
        in_data  = blk[t/4][(t%4)*4 +: 4];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (t < 12) check(in_rdy[0] == 1'b1, "b2b_in_ready", 129'(in_rdy[0]), 129'(1));
      check(o_vld[0] == (t >= 4 && t < 16), "b2b_out_valid", 129'(o_vld[0]), 129'(t >= 4 && t < 16));
      tick();
    end
    drain();

    // Partial block discarded by reset.
    s = rand_st();
    send_beat(s[0 +: 4]);
    send_beat(s[4 +: 4]);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_state("reset_mid_block");
    tick();
    s = iota_st();
    send_block(s, mix(1, s), mix(0, s));
    drain();

    // Round trips through the opposite mix.
    for (int i = 0; i < 4; i++) begin
      s = rand_st();
      f = mix(0, s);
      send_block(f, s, mix(0, f));
      s = rand_st();
      f = mix(1, s);
      send_block(f, mix(1, f), s);
    end
    drain();

    // Random handshake traffic.
    rand_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      s = rand_st();
      send_block(s, mix(1, s), mix(0, s));
    end
    rand_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inv_mix512_stream.md
INV_MIX512_STREAM -- requirements
Module: inv_mix512_stream

Interface
REQ-001 SHALL have parameter INVERSE, default 1: 1 = inverse Haraka-512 word mix; 0 = forward mix.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  in_data holds a valid beat.
REQ-005 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-006 SHALL have port in_data  input  128  input beat, four 32-bit words, word 0 at bits [31:0].
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-008 SHALL have port out_ready  input  1  downstream accepts a beat this cycle.
REQ-009 SHALL have port out_data  output  128  output beat, same word packing as in_data.
REQ-010 SHALL have port out_last  output  1  high on the fourth (final) beat of each output block.

Function
REQ-011 SHALL treat one 512-bit state as four beats; beat b carries state words 4b..4b+3, beat 0 first.
REQ-012 SHALL transfer an input beat only when in_valid && in_ready, and an output beat only when out_valid && out_ready.
REQ-013 SHALL hold two 512-bit banks (ping-pong), each with a full flag, a write bank pointer, a read bank pointer, and 2-bit input and output beat counters.
REQ-014 SHALL drive in_ready = !full[wr_ptr]; out_valid = full[rd_ptr].
REQ-015 SHALL store an accepted beat into word slots 4*in_cnt..4*in_cnt+3 of bank wr_ptr, then increment in_cnt (3 wraps to 0).
REQ-016 SHALL, on accepting beat 3, set full[wr_ptr] and toggle wr_ptr.
REQ-017 SHALL compute output state word k as bank word P(k), with INVERSE=1 table P = 5,9,12,0,7,11,14,2,4,8,13,1,6,10,15,3 for k = 0..15.
REQ-018 SHALL, with INVERSE=0, use forward table P = 3,11,7,15,8,0,12,4,9,1,13,5,2,10,6,14 for k = 0..15.
REQ-019 SHALL drive out_data with permuted words 4*out_cnt..4*out_cnt+3 of bank rd_ptr, and drive 0 when out_valid is low.
REQ-020 SHALL drive out_last = out_valid && (out_cnt == 3).
REQ-021 SHALL, on an output transfer, increment out_cnt; on transferring beat 3, clear full[rd_ptr] and toggle rd_ptr.
REQ-022 SHALL assert out_valid in the cycle after the fourth input beat of a block is accepted (latency 1 cycle).
REQ-023 SHALL sustain one beat per cycle on both sides simultaneously while out_ready stays high (no bubbles between blocks).
REQ-024 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-025 SHALL, when both banks are full, hold in_ready low until the read bank's beat 3 is transferred.
REQ-026 SHALL set in_ready in the cycle after the freeing transfer, not combinationally from out_ready.
REQ-027 SHALL never let fill and drain target the same bank in the same cycle; simultaneous set and clear of full flags on different banks SHALL both take effect.

Reset
REQ-028 SHALL, when rst is high at a clock edge, clear both full flags, both pointers, and both counters, discarding any partial or buffered block.
REQ-029 SHALL, during and after reset, drive in_ready=1, out_valid=0, out_data=0, out_last=0.
REQ-030 SHALL NOT require bank data to be reset.
REQ-031 SHALL give rst priority over any coincident transfer.

Structure
REQ-032 SHALL place the following in a shared package mix512_pkg: NUM_CHUNKS=16, CHUNK_W=32, BEAT_W=128, BEATS=4, the forward and inverse index tables, and a 16x32 word-array typedef.
REQ-033 SHALL isolate the permutation in one combinational sub-module inv_mix512 (parameter INVERSE, 512-bit in/out), instantiated on the read bank.

Verification
REQ-034 Input words w[i]=i, INVERSE=1, out_ready=1 -> output beats, words 0..3 each: {5,9,12,0}, {7,11,14,2}, {4,8,13,1}, {6,10,15,3}; out_last on the 4th beat only; first out_valid 1 cycle after the 4th input beat.
REQ-035 Round trip: feed forward-mixed random state (INVERSE=1) -> original state words returned exactly; repeat with INVERSE=0 fed inverse-mixed data.
REQ-036 out_ready=0, in_valid=1 continuously -> exactly 8 beats accepted, in_ready low from the cycle after the 8th; raising out_ready drains 4 beats, then in_ready rises 1 cycle after the 4th.
REQ-037 Three back-to-back blocks, out_ready=1 -> 12 output beats on consecutive cycles, in_ready never low.
REQ-038 Two input beats, then rst high 1 cycle -> in_ready=1, out_valid=0; the next 4 beats alone form block 0 and match REQ-034.
REQ-039 Random in_valid/out_ready toggling, 1000 blocks -> output stream equals a scoreboard model; out_data stable during every stall.
